// File: rtl/nand_gate_unit_if.sv
// rtl/nand_gate_unit_if.sv - operand/result bundle for the NAND cell
//
// Purpose: groups the operand inputs, capture enable and all result outputs
// of nand_gate_unit so they travel as one port.
// Signals:
//   a, b      operands (WIDTH)
//   en        capture enable for the registered path
//   y         combinational ~(a & b)
//   y_q       registered copy of y
//   valid_q   y_q holds a captured result
//   all_high  &y
//   tog_cnt   saturating count of y_q changes (CNT_W)
// Modports: master drives operands and enable; slave is the NAND cell.

interface nand_gate_unit_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             valid_q;
  logic             all_high;
  logic [CNT_W-1:0] tog_cnt;

  modport master (
    output a, b, en,
    input  y, y_q, valid_q, all_high, tog_cnt
  );

  modport slave (
    input  a, b, en,
    output y, y_q, valid_q, all_high, tog_cnt
  );
endinterface

// File: rtl/nand_gate_unit.sv
// rtl/nand_gate_unit.sv - bitwise NAND cell with registered copy and toggle counter
//
// Purpose: zero-latency bitwise NAND of two operands, plus a clock-aligned
// copy captured when en is high, a sticky valid flag, and a saturating
// counter of the captures that changed the registered value.
// Ports:
//   clk    rising-edge clock for all registered state
//   rst_n  asynchronous active-low reset
//   bus    nand_gate_unit_if slave (a, b, en in; y, y_q, valid_q,
//          all_high, tog_cnt out)

module nand_gate_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  nand_gate_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] nand_w;
  logic [WIDTH-1:0] res_q, res_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational path: no sanitizing, X/Z propagate per bitwise rules.
  assign nand_w = ~(bus.a & bus.b);

  always_comb begin
    res_d = res_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (bus.en) begin
      res_d = nand_w;
      vld_d = 1'b1;
      // Compared against the current register, so the first capture after
      // reset (register = 0) counts whenever the result is nonzero.
      if ((nand_w != res_q) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.y        = nand_w;
  assign bus.all_high = &nand_w;
  assign bus.y_q      = res_q;
  assign bus.valid_q  = vld_q;
  assign bus.tog_cnt  = cnt_q;

endmodule

// File: tb/tb_nand_gate_unit.sv
// tb/tb_nand_gate_unit.sv - directed self-checking bench for nand_gate_unit

module tb_nand_gate_unit;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  nand_gate_unit_if #(.WIDTH(1), .CNT_W(8)) if1 ();
  nand_gate_unit_if #(.WIDTH(4), .CNT_W(8)) if4 ();

  nand_gate_unit #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  nand_gate_unit #(.WIDTH(4), .CNT_W(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Vector table for the WIDTH=1 truth-table pass.
  logic [1:0] ab_vec  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       y_vec   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] cnt_vec [4] = '{8'd1, 8'd1, 8'd1, 8'd2};

  int exp_cnt;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    if1.a   = 1'b0;
    if1.b   = 1'b0;
    if1.en  = 1'b0;
    if4.a   = 4'b0000;
    if4.b   = 4'b0000;
    if4.en  = 1'b0;

    // Reset held: y follows inputs, registered state stays cleared.
    @(negedge clk);
    check("rst_yq", if1.y_q, 0);
    check("rst_valid", if1.valid_q, 0);
    check("rst_cnt", if1.tog_cnt, 0);
    if1.en = 1'b1;
    if1.a  = 1'b1;
    if1.b  = 1'b1;
    #1;
    check("rst_y_11", if1.y, 0);
    @(posedge clk); #1;
    check("rst_yq_11", if1.y_q, 0);
    check("rst_valid_11", if1.valid_q, 0);
    check("rst_cnt_11", if1.tog_cnt, 0);
    @(negedge clk);
    if1.a = 1'b0;
    if1.b = 1'b0;
    #1;
    check("rst_y_00", if1.y, 1);
    @(posedge clk); #1;
    check("rst_yq_00", if1.y_q, 0);
    check("rst_valid_00", if1.valid_q, 0);
    check("rst_cnt_00", if1.tog_cnt, 0);

    // Truth table with en=1, reset released.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      {if1.a, if1.b} = ab_vec[i];
      #1;
      check($sformatf("tt_y_%0d", i), if1.y, y_vec[i]);
      check($sformatf("tt_allh_%0d", i), if1.all_high, y_vec[i]);
      @(posedge clk); #1;
      check($sformatf("tt_yq_%0d", i), if1.y_q, y_vec[i]);
      check($sformatf("tt_valid_%0d", i), if1.valid_q, 1);
      check($sformatf("tt_cnt_%0d", i), if1.tog_cnt, cnt_vec[i]);
    end

    // Hold with en=0: y_q=0 kept, valid stays set.
    @(negedge clk);
    if1.en = 1'b0;
    if1.a  = 1'b0;
    if1.b  = 1'b0;
    #1;
    check("hold_y", if1.y, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_yq_%0d", i), if1.y_q, 0);
      check($sformatf("hold_valid_%0d", i), if1.valid_q, 1);
      check($sformatf("hold_cnt_%0d", i), if1.tog_cnt, 2);
    end

    // Alternate 00/11 for 300 cycles: counter climbs from 2 and saturates.
    exp_cnt = 2;
    if1.en  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if1.a = (i % 2 == 1);
      if1.b = (i % 2 == 1);
      @(posedge clk); #1;
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      check($sformatf("tog_%0d", i), if1.tog_cnt, exp_cnt);
    end
    check("tog_sat", if1.tog_cnt, 255);

    // Capture y=1, then assert reset between edges.
    @(negedge clk);
    if1.a = 1'b0;
    if1.b = 1'b0;
    @(posedge clk); #1;
    check("pre_arst_yq", if1.y_q, 1);
    check("pre_arst_cnt", if1.tog_cnt, 255);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_yq", if1.y_q, 0);
    check("arst_cnt", if1.tog_cnt, 0);
    check("arst_valid", if1.valid_q, 0);

    // WIDTH=4 vectors on the second instance.
    @(negedge clk);
    rst_n  = 1'b1;
    if1.en = 1'b0;
    if4.en = 1'b1;
    if4.a  = 4'b1100;
    if4.b  = 4'b1010;
    #1;
    check("w4_y_a", if4.y, 4'b0111);
    check("w4_allh_a", if4.all_high, 0);
    @(posedge clk); #1;
    check("w4_yq_a", if4.y_q, 4'b0111);
    check("w4_cnt_a", if4.tog_cnt, 1);
    check("w4_valid_a", if4.valid_q, 1);
    @(negedge clk);
    if4.a = 4'b0000;
    #1;
    check("w4_y_b", if4.y, 4'b1111);
    check("w4_allh_b", if4.all_high, 1);
    @(posedge clk); #1;
    check("w4_yq_b", if4.y_q, 4'b1111);
    check("w4_cnt_b", if4.tog_cnt, 2);
    check("w1_idle_yq", if1.y_q, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
